rdma_recv_v2: RTL and testbench
===============================

# rdma_recv_v2

Second-generation RDMA receive engine. It accepts RDMA packets on an AXI-Stream input and issues the matching AXI4 write bursts on a write-only AXI4 master. It decouples the AW and W channels with an AW FIFO, validates headers and drops bad ones, enforces beat count against burst length, limits outstanding writes, and exposes status counters. It sits between the packet-receive stream and the memory interconnect.

## Interface
- DATA_WIDTH, 512: AXI/AXIS data width in bits; multiple of 128.
- ADDR_WIDTH, 64: AXI address width in bits; ≤ 64.
- AW_FIFO_DEPTH, 4: AW FIFO entries; power of 2, ≥ 2.
- MAX_OUTSTANDING, 16: writes accepted with no B response yet; ≥ 1.
- HDR_MAGIC, 16'hD0A5: required header magic value.
---
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- AXIS_RDMA_TDATA/TKEEP/TVALID/TLAST  in  DATA_WIDTH/DATA_WIDTH/8/1/1  packet stream.
- AXIS_RDMA_TREADY  out  1  stream ready.
- M_AXI_AWADDR/AWLEN/AWVALID  out  ADDR_WIDTH/8/1  AW channel.
- M_AXI_AWREADY  in  1  AW ready.
- AWSIZE = log2(DATA_WIDTH/8), AWBURST = INCR, AWID/AWLOCK/AWCACHE/AWQOS = 0, AWPROT = 1; all constant.
- M_AXI_WDATA/WSTRB/WLAST/WVALID  out  DATA_WIDTH/DATA_WIDTH/8/1/1  W channel.
- M_AXI_WREADY  in  1  W ready.
- M_AXI_BRESP/BVALID  in  2/1  B channel. M_AXI_BREADY  out  1, constant 1.
- pkt_count, drop_count, len_err_count, bresp_err_count  out  32 each  wrapping event counters.
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  number of writes in flight.

## Operation
- The header is the first beat of a packet. Fields are taken from the byte-swapped beat, where byte 0 is the most-significant byte of TDATA:
  - magic: bytes 40–41.
  - addr: bytes 42–49, truncated to ADDR_WIDTH.
  - len: byte 50.
- A header is good when magic == HDR_MAGIC and TLAST = 0.
- A header is bad otherwise.
- States: HDR, XFER, PAD, DRAIN, DROP.
- HDR:
  - TREADY = !fifo_full && outstanding < MAX_OUTSTANDING.
  - Good header: push {addr, len} to the FIFO, increment outstanding, load beat_cnt = 0 and cur_len = len, go to XFER.
  - Bad header with TLAST = 1: drop_count++, stay in HDR.
  - Bad header with TLAST = 0: drop_count++, go to DROP.
- XFER:
  - W is driven straight from the stream. WVALID = TVALID, TREADY = WREADY, WSTRB = TKEEP.
  - WLAST = (beat_cnt == cur_len). The module generates WLAST; TLAST is not used for it.
  - On each W handshake, beat_cnt++.
  - On the WLAST beat with TLAST = 1: pkt_count++, go to HDR.
  - On the WLAST beat with TLAST = 0: len_err_count++, go to DRAIN.
  - On TLAST before the WLAST beat: len_err_count++, go to PAD.
- PAD:
  - TREADY = 0. Drive WVALID = 1, WSTRB = 0, WDATA = 0 until the WLAST beat handshakes, then go to HDR.
- DRAIN and DROP:
  - TREADY = 1, W is idle. Beats are discarded until TLAST, then go to HDR.
- AW path:
  - The FIFO head drives AWADDR/AWLEN, and AWVALID = !fifo_empty.
  - The entry pops on the AW handshake.
  - AW may lead or lag W by any amount up to the FIFO depth.
- Outstanding counter:
  - +1 on good-header accept, −1 on a B handshake; both in the same cycle leaves it unchanged.
  - Never exceeds MAX_OUTSTANDING. A B handshake at 0 is ignored.
- bresp_err_count increments on a B handshake with BRESP ≠ 0.

## Timing
- Header accept to AWVALID = 1: one clk, because the FIFO output is registered.
- W path: zero added latency in XFER, combinational pass-through.
- AWVALID, once high, holds with stable AWADDR/AWLEN until AWREADY.
- WVALID in PAD holds until WREADY.
- FIFO full, or outstanding == MAX_OUTSTANDING: the header beat is back-pressured. Data-phase beats are never blocked by AW.
- Simultaneous FIFO push and pop when full: the push is not allowed, because TREADY was low. When empty: the pushed entry appears on the next cycle.
- Reset, asynchronous at any point: state = HDR, FIFO empty, all counters = 0, outstanding = 0.
- Reset value of every output is 0, except the constant AW fields and BREADY = 1. TREADY may rise on the first clk after reset deasserts.
- A partial burst interrupted by reset is abandoned. No completion is attempted.

## Structure
- Package rdma_pkg holds:
  - the header byte offsets (40, 42, 50) and the default HDR_MAGIC;
  - the state enum {HDR, XFER, PAD, DRAIN, DROP};
  - the AW FIFO entry struct {addr, len}.
- Sub-module rdma_aw_fifo: synchronous FIFO with registered output, push/pop and full/empty flags, parametrised width and depth.

## Test plan
- Good header, addr = 0x1000_0000, len = 3, four data beats with TLAST on beat 4, AWREADY = 1:
  - one AW (0x1000_0000, 3), four W beats, WLAST on beat 4, pkt_count = 1.
- Bad magic 0xBEEF followed by 5 beats:
  - no AW or W activity, all 6 beats consumed, drop_count = 1.
- len = 3 with TLAST on data beat 2:
  - 2 real beats, then 2 pad beats with WSTRB = 0, WLAST on beat 4, len_err_count = 1.
- len = 1 with a 4-beat payload:
  - 2 W beats, WLAST on the 2nd, 2 beats drained, len_err_count = 1.
- AWREADY = 0 while 4 packets arrive (AW_FIFO_DEPTH = 4):
  - all 4 W bursts complete.
  - The 5th header stalls with TREADY = 0 until AWREADY rises.
  - AWs then emerge in order.
- MAX_OUTSTANDING = 2 with BVALID held low:
  - the 3rd header stalls.
  - One B with BRESP = 2 releases it, bresp_err_count = 1.
  - A B handshake coinciding with a header accept leaves outstanding unchanged.

Source files
------------

// File: rtl/rdma_pkg.sv
// rdma_pkg: shared definitions for the rdma_recv_v2 receive engine.
// Contents: header byte offsets, default header magic, receive FSM state
// encoding and the AW FIFO entry layout.
package rdma_pkg;

  // Byte offsets inside the header beat. Byte 0 is the most-significant
  // byte of TDATA, so multi-byte fields read in network (big-endian) order.
  localparam int HDR_MAGIC_OFS = 40;
  localparam int HDR_ADDR_OFS  = 42;
  localparam int HDR_LEN_OFS   = 50;

  localparam logic [15:0] HDR_MAGIC_DEFAULT = 16'hD0A5;

  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_XFER  = 3'd1,
    ST_PAD   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DROP  = 3'd4
  } rx_state_e;

  // One pending AW request. addr is kept at full 64 bits and truncated to
  // the bus address width at the AW port.
  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
  } aw_entry_t;

  // Bit index of the MSB of byte 'idx' in a beat of 'dw' bits.
  function automatic int byte_msb(input int dw, input int idx);
    return dw - 1 - 8 * idx;
  endfunction

endpackage

// File: rtl/rdma_aw_fifo.sv
// rdma_aw_fifo: synchronous FIFO holding pending AW requests.
// Latency: a pushed entry is visible at dout_o on the next clk (head read from flops).
// Backpressure: push ignored when full, pop ignored when empty; caller gates with flags.
// Ports: clk/rst, push_i+din_i, pop_i, dout_o (head entry), full_o, empty_o.
module rdma_aw_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      cnt_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Storage is reset so the AW outputs read as zero out of reset.
  assign dout_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/rdma_recv_v2.sv
// rdma_recv_v2: RDMA receive engine, AXI-Stream packets in, AXI4 write bursts out.
// Latency: header accept to AWVALID one clk; W data is a zero-latency pass-through.
// Backpressure: header beat stalls on AW FIFO full or outstanding limit; data beats follow WREADY.
// Ports: clk/reset; AXIS_RDMA_* packet stream; M_AXI_AW*/W*/B* write master (constant
// AW attributes, BREADY tied high); pkt/drop/len_err/bresp_err wrapping counters; outstanding.
module rdma_recv_v2
  import rdma_pkg::*;
#(
  parameter int          DATA_WIDTH      = 512,
  parameter int          ADDR_WIDTH      = 64,
  parameter int          AW_FIFO_DEPTH   = 4,
  parameter int          MAX_OUTSTANDING = 16,
  parameter logic [15:0] HDR_MAGIC       = HDR_MAGIC_DEFAULT
) (
  input  logic                                     clk,
  input  logic                                     reset,
  // packet stream
  input  logic [DATA_WIDTH-1:0]                    AXIS_RDMA_TDATA,
  input  logic [DATA_WIDTH/8-1:0]                  AXIS_RDMA_TKEEP,
  input  logic                                     AXIS_RDMA_TVALID,
  input  logic                                     AXIS_RDMA_TLAST,
  output logic                                     AXIS_RDMA_TREADY,
  // AW channel
  output logic [ADDR_WIDTH-1:0]                    M_AXI_AWADDR,
  output logic [7:0]                               M_AXI_AWLEN,
  output logic                                     M_AXI_AWVALID,
  input  logic                                     M_AXI_AWREADY,
  output logic [2:0]                               M_AXI_AWSIZE,
  output logic [1:0]                               M_AXI_AWBURST,
  output logic                                     M_AXI_AWID,
  output logic                                     M_AXI_AWLOCK,
  output logic [3:0]                               M_AXI_AWCACHE,
  output logic [3:0]                               M_AXI_AWQOS,
  output logic [2:0]                               M_AXI_AWPROT,
  // W channel
  output logic [DATA_WIDTH-1:0]                    M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]                  M_AXI_WSTRB,
  output logic                                     M_AXI_WLAST,
  output logic                                     M_AXI_WVALID,
  input  logic                                     M_AXI_WREADY,
  // B channel
  input  logic [1:0]                               M_AXI_BRESP,
  input  logic                                     M_AXI_BVALID,
  output logic                                     M_AXI_BREADY,
  // status
  output logic [31:0]                              pkt_count,
  output logic [31:0]                              drop_count,
  output logic [31:0]                              len_err_count,
  output logic [31:0]                              bresp_err_count,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

  // ---------------------------------------------------------------------------
  // Constant AW attributes and B ready
  // ---------------------------------------------------------------------------
  assign M_AXI_AWSIZE  = 3'($clog2(KW));
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWID    = 1'b0;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = 4'b0000;
  assign M_AXI_AWQOS   = 4'b0000;
  assign M_AXI_AWPROT  = 3'b001;
  assign M_AXI_BREADY  = 1'b1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  rx_state_e       state_q;
  logic [7:0]      beat_cnt_q;
  logic [7:0]      cur_len_q;
  logic [OW-1:0]   out_q;
  logic [31:0]     pkt_cnt_q;
  logic [31:0]     drop_cnt_q;
  logic [31:0]     len_err_cnt_q;
  logic [31:0]     bresp_err_cnt_q;
  // Holds TREADY low while reset is asserted and for the first clk after it.
  logic            rdy_en_q;

  // ---------------------------------------------------------------------------
  // Header decode
  // ---------------------------------------------------------------------------
  logic [15:0]           hdr_magic;
  logic [63:0]           hdr_addr64;
  logic [7:0]            hdr_len;
  logic                  hdr_good;

  assign hdr_magic  = AXIS_RDMA_TDATA[byte_msb(DATA_WIDTH, HDR_MAGIC_OFS) -: 16];
  assign hdr_addr64 = AXIS_RDMA_TDATA[byte_msb(DATA_WIDTH, HDR_ADDR_OFS)  -: 64];
  assign hdr_len    = AXIS_RDMA_TDATA[byte_msb(DATA_WIDTH, HDR_LEN_OFS)   -: 8];
  // A single-beat packet carries no payload, so it is treated as malformed.
  assign hdr_good   = (hdr_magic == HDR_MAGIC) && !AXIS_RDMA_TLAST;

  // ---------------------------------------------------------------------------
  // AW FIFO
  // ---------------------------------------------------------------------------
  aw_entry_t fifo_din;
  aw_entry_t fifo_dout;
  logic      fifo_full;
  logic      fifo_empty;
  logic      fifo_push;
  logic      fifo_pop;

  assign fifo_din.addr = 64'(hdr_addr64[ADDR_WIDTH-1:0]);
  assign fifo_din.len  = hdr_len;

  rdma_aw_fifo #(
    .WIDTH ($bits(aw_entry_t)),
    .DEPTH (AW_FIFO_DEPTH)
  ) u_aw_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (fifo_push),
    .din_i   (fifo_din),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign M_AXI_AWADDR  = fifo_dout.addr[ADDR_WIDTH-1:0];
  assign M_AXI_AWLEN   = fifo_dout.len;
  assign M_AXI_AWVALID = !fifo_empty;
  assign fifo_pop      = M_AXI_AWVALID && M_AXI_AWREADY;

  // ---------------------------------------------------------------------------
  // Stream / W channel steering
  // ---------------------------------------------------------------------------
  logic tready_c;
  logic beat_last;
  logic t_hs;
  logic w_hs;
  logic b_hs;
  logic hdr_accept;
  logic out_inc;
  logic out_dec;

  assign beat_last = (beat_cnt_q == cur_len_q);

  always_comb begin
    tready_c     = 1'b0;
    M_AXI_WVALID = 1'b0;
    M_AXI_WDATA  = '0;
    M_AXI_WSTRB  = '0;
    M_AXI_WLAST  = 1'b0;
    case (state_q)
      ST_HDR: begin
        tready_c = !fifo_full && (out_q < MAX_OUT);
      end
      ST_XFER: begin
        tready_c     = M_AXI_WREADY;
        M_AXI_WVALID = AXIS_RDMA_TVALID;
        M_AXI_WDATA  = AXIS_RDMA_TDATA;
        M_AXI_WSTRB  = AXIS_RDMA_TKEEP;
        M_AXI_WLAST  = beat_last;
      end
      ST_PAD: begin
        // Stream paused; fill the burst with null-strobe beats.
        M_AXI_WVALID = 1'b1;
        M_AXI_WLAST  = beat_last;
      end
      ST_DRAIN, ST_DROP: begin
        tready_c = 1'b1;
      end
      default: begin
        tready_c = 1'b0;
      end
    endcase
  end

  assign AXIS_RDMA_TREADY = tready_c && rdy_en_q;

  assign t_hs       = AXIS_RDMA_TVALID && AXIS_RDMA_TREADY;
  assign w_hs       = M_AXI_WVALID && M_AXI_WREADY;
  assign b_hs       = M_AXI_BVALID;  // BREADY is tied high
  assign hdr_accept = (state_q == ST_HDR) && t_hs && hdr_good;
  assign fifo_push  = hdr_accept;
  assign out_inc    = hdr_accept;
  assign out_dec    = b_hs && (out_q != '0);

  // ---------------------------------------------------------------------------
  // Receive FSM and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_HDR;
      beat_cnt_q      <= '0;
      cur_len_q       <= '0;
      out_q           <= '0;
      pkt_cnt_q       <= '0;
      drop_cnt_q      <= '0;
      len_err_cnt_q   <= '0;
      bresp_err_cnt_q <= '0;
      rdy_en_q        <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;

      case (state_q)
        ST_HDR: begin
          if (t_hs) begin
            if (hdr_good) begin
              beat_cnt_q <= '0;
              cur_len_q  <= hdr_len;
              state_q    <= ST_XFER;
            end else begin
              drop_cnt_q <= drop_cnt_q + 32'd1;
              state_q    <= AXIS_RDMA_TLAST ? ST_HDR : ST_DROP;
            end
          end
        end
        ST_XFER: begin
          if (w_hs) begin
            beat_cnt_q <= beat_cnt_q + 8'd1;
            if (beat_last) begin
              if (AXIS_RDMA_TLAST) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
                state_q   <= ST_HDR;
              end else begin
                // Burst full but packet continues: discard the excess.
                len_err_cnt_q <= len_err_cnt_q + 32'd1;
                state_q       <= ST_DRAIN;
              end
            end else if (AXIS_RDMA_TLAST) begin
              // Packet ended early: the burst length is committed on AW,
              // so the remaining beats must still be issued.
              len_err_cnt_q <= len_err_cnt_q + 32'd1;
              state_q       <= ST_PAD;
            end
          end
        end
        ST_PAD: begin
          if (M_AXI_WREADY) begin
            beat_cnt_q <= beat_cnt_q + 8'd1;
            if (beat_last) begin
              state_q <= ST_HDR;
            end
          end
        end
        ST_DRAIN, ST_DROP: begin
          if (AXIS_RDMA_TVALID && AXIS_RDMA_TLAST) begin
            state_q <= ST_HDR;
          end
        end
        default: begin
          state_q <= ST_HDR;
        end
      endcase

      case ({out_inc, out_dec})
        2'b10:   out_q <= out_q + OW'(1);
        2'b01:   out_q <= out_q - OW'(1);
        default: out_q <= out_q;
      endcase

      if (b_hs && (M_AXI_BRESP != 2'b00)) begin
        bresp_err_cnt_q <= bresp_err_cnt_q + 32'd1;
      end
    end
  end

  assign pkt_count       = pkt_cnt_q;
  assign drop_count      = drop_cnt_q;
  assign len_err_count   = len_err_cnt_q;
  assign bresp_err_count = bresp_err_cnt_q;
  assign outstanding     = out_q;

endmodule

// File: tb/tb_rdma_recv_v2.sv
// Testbench for rdma_recv_v2: directed packets, scoreboard queues for AW and W,
// and a monitor that pops and compares on every AW/W handshake.
module tb_rdma_recv_v2;

  localparam int DW  = 512;
  localparam int KW  = DW / 8;
  localparam int AWD = 64;
  localparam int OW  = 2;  // $clog2(MAX_OUTSTANDING+1) for MAX_OUTSTANDING = 2
  localparam logic [15:0] MAGIC = 16'hD0A5;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   tdata;
  logic [KW-1:0]   tkeep;
  logic            tvalid, tlast, tready;
  logic [AWD-1:0]  awaddr;
  logic [7:0]      awlen;
  logic            awvalid, awready;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awid, awlock;
  logic [3:0]      awcache, awqos;
  logic [2:0]      awprot;
  logic [DW-1:0]   wdata;
  logic [KW-1:0]   wstrb;
  logic            wlast, wvalid, wready;
  logic [1:0]      bresp;
  logic            bvalid, bready;
  logic [31:0]     pkt_count, drop_count, len_err_count, bresp_err_count;
  logic [OW-1:0]   outstanding;

  always #5 clk = ~clk;

  rdma_recv_v2 #(
    .DATA_WIDTH      (DW),
    .ADDR_WIDTH      (AWD),
    .AW_FIFO_DEPTH   (4),
    .MAX_OUTSTANDING (2),
    .HDR_MAGIC       (MAGIC)
  ) dut (
    .clk              (clk),
    .reset            (rst),
    .AXIS_RDMA_TDATA  (tdata),
    .AXIS_RDMA_TKEEP  (tkeep),
    .AXIS_RDMA_TVALID (tvalid),
    .AXIS_RDMA_TLAST  (tlast),
    .AXIS_RDMA_TREADY (tready),
    .M_AXI_AWADDR     (awaddr),
    .M_AXI_AWLEN      (awlen),
    .M_AXI_AWVALID    (awvalid),
    .M_AXI_AWREADY    (awready),
    .M_AXI_AWSIZE     (awsize),
    .M_AXI_AWBURST    (awburst),
    .M_AXI_AWID       (awid),
    .M_AXI_AWLOCK     (awlock),
    .M_AXI_AWCACHE    (awcache),
    .M_AXI_AWQOS      (awqos),
    .M_AXI_AWPROT     (awprot),
    .M_AXI_WDATA      (wdata),
    .M_AXI_WSTRB      (wstrb),
    .M_AXI_WLAST      (wlast),
    .M_AXI_WVALID     (wvalid),
    .M_AXI_WREADY     (wready),
    .M_AXI_BRESP      (bresp),
    .M_AXI_BVALID     (bvalid),
    .M_AXI_BREADY     (bready),
    .pkt_count        (pkt_count),
    .drop_count       (drop_count),
    .len_err_count    (len_err_count),
    .bresp_err_count  (bresp_err_count),
    .outstanding      (outstanding)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] s;
    logic          l;
  } w_exp_t;

  typedef struct {
    logic [AWD-1:0] a;
    logic [7:0]     n;
  } aw_exp_t;

  w_exp_t  wq[$];
  aw_exp_t awq[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Header beat built byte by byte: byte 0 lands in the MSB of TDATA.
  function automatic logic [DW-1:0] mk_hdr(input logic [15:0] magic, input logic [63:0] addr,
                                           input logic [7:0] len);
    logic [7:0]    b [KW];
    logic [DW-1:0] h;
    for (int k = 0; k < KW; k++) b[k] = 8'(8'h30 + k);  // filler around the fields
    b[40] = magic[15:8];
    b[41] = magic[7:0];
    for (int i = 0; i < 8; i++) b[42+i] = addr[63-8*i -: 8];
    b[50] = len;
    h = '0;
    for (int k = 0; k < KW; k++) h[DW-1-8*k -: 8] = b[k];
    return h;
  endfunction

  function automatic logic [DW-1:0] payload(input int tag, input int i);
    logic [31:0] w;
    w = 32'hA500_0000 | (32'(tag) << 8) | 32'(i);
    return {16{w}};
  endfunction

  task automatic exp_aw(input logic [63:0] a, input logic [7:0] n);
    awq.push_back('{a, n});
  endtask

  task automatic exp_w(input int tag, input int i, input logic l);
    wq.push_back('{payload(tag, i), {KW{1'b1}}, l});
  endtask

  task automatic exp_pad(input logic l);
    wq.push_back('{'0, '0, l});
  endtask

  // Present one beat and hold it until the handshake edge (bounded).
  task automatic axis_beat(input logic [DW-1:0] d, input logic l);
    int n = 0;
    tdata  = d;
    tkeep  = '1;
    tlast  = l;
    tvalid = 1'b1;
    @(negedge clk);
    while (!tready) begin
      n++;
      if (n > 300) begin
        checks++;
        errors++;
        $display("FAIL tready_timeout: got tready=0 for %0d cycles expected 1", n);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] m, input logic [63:0] a, input logic [7:0] n,
                          input logic l);
    axis_beat(mk_hdr(m, a, n), l);
  endtask

  task automatic send_data(input int tag, input int n);
    for (int i = 0; i < n; i++) axis_beat(payload(tag, i), (i == n - 1));
  endtask

  task automatic b_pulse(input logic [1:0] r);
    bresp  = r;
    bvalid = 1'b1;
    @(posedge clk);
    #1;
    bvalid = 1'b0;
    bresp  = 2'b00;
  endtask

  task automatic monitor();
    aw_exp_t ea;
    w_exp_t  ew;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (awvalid && awready) begin
          checks++;
          if (awq.size() == 0) begin
            errors++;
            $display("FAIL aw_unexpected: got addr=%0h len=%0d expected no AW", awaddr, awlen);
          end else begin
            ea = awq.pop_front();
            if (awaddr !== ea.a || awlen !== ea.n) begin
              errors++;
              $display("FAIL aw_beat: got addr=%0h len=%0d expected addr=%0h len=%0d",
                       awaddr, awlen, ea.a, ea.n);
            end
          end
        end
        if (wvalid && wready) begin
          checks++;
          if (wq.size() == 0) begin
            errors++;
            $display("FAIL w_unexpected: got strb=%0h last=%0b expected no W", wstrb, wlast);
          end else begin
            ew = wq.pop_front();
            if (wdata !== ew.d || wstrb !== ew.s || wlast !== ew.l) begin
              errors++;
              $display("FAIL w_beat: got data=%0h strb=%0h last=%0b expected data=%0h strb=%0h last=%0b",
                       wdata, wstrb, wlast, ew.d, ew.s, ew.l);
            end
          end
        end
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    tdata   = '0;
    tkeep   = '0;
    tvalid  = 1'b0;
    tlast   = 1'b0;
    awready = 1'b1;
    wready  = 1'b1;
    bresp   = 2'b00;
    bvalid  = 1'b0;

    fork
      monitor();
      begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tready", tready, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_awaddr", awaddr, 0);
    check("rst_pkt", pkt_count, 0);
    check("rst_drop", drop_count, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_bready", bready, 1);
    check("awsize", awsize, 6);
    check("awburst", awburst, 1);
    check("awprot", awprot, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("tready_after_rst", tready, 1);
    @(posedge clk);
    #1;

    // Good packet: len 3, four data beats
    exp_aw(64'h1000_0000, 8'd3);
    exp_w(1, 0, 0); exp_w(1, 1, 0); exp_w(1, 2, 0); exp_w(1, 3, 1);
    send_hdr(MAGIC, 64'h1000_0000, 8'd3, 1'b0);
    check("awvalid_one_clk", awvalid, 1);
    send_data(1, 4);
    repeat (3) @(posedge clk);
    #1;
    check("pkt_after_good", pkt_count, 1);
    check("out_after_good", outstanding, 1);
    b_pulse(2'b00);
    check("out_after_b", outstanding, 0);

    // Bad magic plus five beats, then a single-beat header with good magic
    send_hdr(16'hBEEF, 64'h5555_0000, 8'd2, 1'b0);
    send_data(2, 5);
    send_hdr(MAGIC, 64'h6666_0000, 8'd0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("drop_count", drop_count, 2);
    check("out_after_drop", outstanding, 0);

    // Short packet: len 3, TLAST on data beat 2, two pad beats
    exp_aw(64'h2000_0040, 8'd3);
    exp_w(3, 0, 0); exp_w(3, 1, 0); exp_pad(0); exp_pad(1);
    send_hdr(MAGIC, 64'h2000_0040, 8'd3, 1'b0);
    send_data(3, 2);
    repeat (5) @(posedge clk);
    #1;
    check("len_err_short", len_err_count, 1);
    check("pkt_after_short", pkt_count, 1);
    b_pulse(2'b00);

    // Long packet: len 1, four-beat payload, last two drained
    exp_aw(64'h3000_0000, 8'd1);
    exp_w(4, 0, 0); exp_w(4, 1, 1);
    send_hdr(MAGIC, 64'h3000_0000, 8'd1, 1'b0);
    send_data(4, 4);
    repeat (3) @(posedge clk);
    #1;
    check("len_err_long", len_err_count, 2);
    b_pulse(2'b00);

    // AW FIFO fill with AWREADY low; B responses keep outstanding clear
    awready = 1'b0;
    for (int p = 0; p < 4; p++) begin
      exp_aw(64'h4000_0000 + 64'(p) * 64'h100, 8'd0);
      exp_w(10 + p, 0, 1);
      send_hdr(MAGIC, 64'h4000_0000 + 64'(p) * 64'h100, 8'd0, 1'b0);
      send_data(10 + p, 1);
      b_pulse(2'b00);
    end
    check("pkt_after_fill", pkt_count, 5);
    check("out_after_fill", outstanding, 0);
    exp_aw(64'h4000_0400, 8'd0);
    exp_w(14, 0, 1);
    fork
      begin
        send_hdr(MAGIC, 64'h4000_0400, 8'd0, 1'b0);
        send_data(14, 1);
      end
      begin
        repeat (5) @(negedge clk);
        check("tready_fifo_full", tready, 0);
        check("awvalid_held", awvalid, 1);
        check("awaddr_held", awaddr, 64'h4000_0000);
        @(posedge clk);
        #1 awready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    b_pulse(2'b00);
    check("pkt_after_fifo", pkt_count, 6);

    // Outstanding limit of 2 with B held low
    exp_aw(64'h5000_0000, 8'd0); exp_w(20, 0, 1);
    send_hdr(MAGIC, 64'h5000_0000, 8'd0, 1'b0);
    send_data(20, 1);
    exp_aw(64'h5000_1000, 8'd0); exp_w(21, 0, 1);
    send_hdr(MAGIC, 64'h5000_1000, 8'd0, 1'b0);
    send_data(21, 1);
    check("out_at_limit", outstanding, 2);
    exp_aw(64'h5000_2000, 8'd0); exp_w(22, 0, 1);
    fork
      begin
        send_hdr(MAGIC, 64'h5000_2000, 8'd0, 1'b0);
        send_data(22, 1);
      end
      begin
        repeat (5) @(negedge clk);
        check("tready_out_limit", tready, 0);
        @(posedge clk);
        #1;
        b_pulse(2'b10);
      end
    join
    check("out_after_release", outstanding, 2);
    check("bresp_err", bresp_err_count, 1);
    b_pulse(2'b00);
    check("out_before_coincide", outstanding, 1);
    // B handshake on the same edge as a header accept
    exp_aw(64'h5000_3000, 8'd0); exp_w(23, 0, 1);
    bresp  = 2'b00;
    bvalid = 1'b1;
    send_hdr(MAGIC, 64'h5000_3000, 8'd0, 1'b0);
    bvalid = 1'b0;
    check("out_coincide", outstanding, 1);
    send_data(23, 1);
    b_pulse(2'b00);
    check("out_final", outstanding, 0);

    repeat (10) @(posedge clk);
    #1;
    check("pkt_final", pkt_count, 10);
    check("drop_final", drop_count, 2);
    check("len_err_final", len_err_count, 2);
    check("bresp_err_final", bresp_err_count, 1);
    check("aw_queue_left", awq.size(), 0);
    check("w_queue_left", wq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
